// File: rtl/icache_refill_if.sv
// Line-request and word-bus signals of the icache refill engine.
// slave: the refill unit; master: the cache controller plus memory side driving it.
interface icache_refill_if #(
    parameter int LINE_WORDS = 4,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32
);
    localparam int LINE_W = LINE_WORDS * WORD_W;

    logic              req_valid_i;
    logic              req_rw_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [LINE_W-1:0] req_data_i;
    logic [LINE_W-1:0] resp_data_o;
    logic              resp_ready_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [WORD_W-1:0] bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [WORD_W-1:0] bus_rdata_i;
    logic              busy_o;

    modport slave (
        input  req_valid_i, req_rw_i, req_addr_i, req_data_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output resp_data_o, resp_ready_o, bus_req_o, bus_we_o,
        output bus_addr_o, bus_wdata_o, busy_o
    );

    modport master (
        output req_valid_i, req_rw_i, req_addr_i, req_data_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  resp_data_o, resp_ready_o, bus_req_o, bus_we_o,
        input  bus_addr_o, bus_wdata_o, busy_o
    );
endinterface

// File: rtl/icache_refill_unit.sv
// Splits one cache-line read/write into four single-beat word transfers.
// Define ICACHE_REFILL_CWF_EN for critical-word-first beat ordering.
module icache_refill_unit #(
    parameter int LINE_WORDS = 4,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32
) (
    input logic            clk_i,
    input logic            rst_ni,
    icache_refill_if.slave rf
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

    state_e                               state_q;
    logic                                 armed_q;
    logic                                 rw_q;
    logic                                 busy_q;
    logic                                 resp_ready_q;
    logic                                 bus_req_q;
    logic                                 bus_we_q;
    logic [1:0]                           cnt_q;
    logic [1:0]                           widx_q;
    logic [ADDR_W-1:0]                    base_q;
    logic [ADDR_W-1:0]                    bus_addr_q;
    logic [WORD_W-1:0]                    bus_wdata_q;
    logic [LINE_WORDS-1:0][WORD_W-1:0]    wline_q;
    logic [LINE_WORDS-1:0][WORD_W-1:0]    rline_q;

    logic [LINE_WORDS-1:0][WORD_W-1:0]    req_line_d;
    logic [ADDR_W-1:0]                    req_base_d;
    logic [1:0]                           start_d;
    logic [1:0]                           nidx_d;
    logic [ADDR_W-1:0]                    naddr_d;
    logic                                 last_d;

    assign req_line_d = rf.req_data_i;
    assign req_base_d = rf.req_addr_i & ~ADDR_W'(15);
`ifdef ICACHE_REFILL_CWF_EN
    assign start_d = rf.req_addr_i[3:2];
`else
    assign start_d = 2'd0;
`endif
    // Offset wraps in 2 bits; the line base is never incremented.
    assign nidx_d  = widx_q + 2'd1;
    assign naddr_d = base_q | ADDR_W'({nidx_d, 2'b00});
    assign last_d  = (cnt_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            armed_q      <= 1'b1;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            resp_ready_q <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            cnt_q        <= 2'd0;
            widx_q       <= 2'd0;
            base_q       <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            wline_q      <= '0;
            rline_q      <= '0;
        end else begin
            resp_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rf.req_valid_i) armed_q <= 1'b1;
                    if (rf.req_valid_i && armed_q) begin
                        state_q     <= S_ADDR;
                        busy_q      <= 1'b1;
                        bus_req_q   <= 1'b1;
                        rw_q        <= rf.req_rw_i;
                        bus_we_q    <= rf.req_rw_i;
                        base_q      <= req_base_d;
                        wline_q     <= req_line_d;
                        cnt_q       <= 2'd0;
                        widx_q      <= start_d;
                        bus_addr_q  <= req_base_d | ADDR_W'({start_d, 2'b00});
                        bus_wdata_q <= req_line_d[start_d];
                    end
                end
                S_ADDR: begin
                    if (rf.bus_gnt_i) begin
                        if (!rw_q) begin
                            state_q   <= S_DATA;
                            bus_req_q <= 1'b0;
                        end else if (last_d) begin
                            state_q      <= S_RESP;
                            bus_req_q    <= 1'b0;
                            bus_we_q     <= 1'b0;
                            resp_ready_q <= 1'b1;
                            armed_q      <= 1'b0;
                        end else begin
                            cnt_q       <= cnt_q + 2'd1;
                            widx_q      <= nidx_d;
                            bus_addr_q  <= naddr_d;
                            bus_wdata_q <= wline_q[nidx_d];
                        end
                    end
                end
                S_DATA: begin
                    if (rf.bus_rvalid_i) begin
                        rline_q[widx_q] <= rf.bus_rdata_i;
                        if (last_d) begin
                            state_q      <= S_RESP;
                            resp_ready_q <= 1'b1;
                            armed_q      <= 1'b0;
                        end else begin
                            state_q    <= S_ADDR;
                            bus_req_q  <= 1'b1;
                            cnt_q      <= cnt_q + 2'd1;
                            widx_q     <= nidx_d;
                            bus_addr_q <= naddr_d;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rf.resp_data_o  = rline_q;
    assign rf.resp_ready_o = resp_ready_q;
    assign rf.bus_req_o    = bus_req_q;
    assign rf.bus_we_o     = bus_we_q;
    assign rf.bus_addr_o   = bus_addr_q;
    assign rf.bus_wdata_o  = bus_wdata_q;
    assign rf.busy_o       = busy_q;
endmodule
